keypad_scanner: RTL and testbench
=================================

Name: keypad_scanner

Overview:
- Multiplexed 4x4 matrix keypad scanner. It is the input-side counterpart of the multiplexed seven-segment driver.
- Drives one active-low row strobe at a time and samples the active-low column returns.
- Debounces over whole scans and emits a one-cycle KeyValid pulse with a 4-bit key code.
- The code is also zero-extended to 6 bits so the time-set logic can load it straight into a display digit.

Parameters:
- SCAN_DIV_BITS, 17: row dwell = 2^SCAN_DIV_BITS Clk cycles (matches the display mux rate at 100 MHz); legal minimum 3.
- DEBOUNCE_SCANS, 4: consecutive identical full-scan results needed to accept a press or a release; range 2..15.

Ports:
- Clk  input  1  system clock, 100 MHz.
- Reset  input  1  asynchronous, active-low reset.
- Cols  input  4  column returns, active-low, pulled up off-chip, asynchronous to Clk.
- Rows  output  4  row strobes, active-low, exactly one low at any time.
- KeyValid  output  1  one-cycle pulse when a debounced press is accepted.
- KeyCode  output  4  code of the last accepted key; held until the next accepted press.
- KeyBCD  output  6  {2'b00, KeyCode}.
- KeyDown  output  1  high from acceptance until release is debounced.

Behaviour:
- Reset (async assert, sync release):
  - Rows=4'b1110, KeyValid=0, KeyCode=0, KeyBCD=0, KeyDown=0.
  - Prescaler=0, state=IDLE, synchroniser=4'hF, debounce count=0.
- Column synchroniser: Cols passes through 2 flops; only the synchronised value is used.
- Row timing:
  - The prescaler counts every cycle.
  - In the cycle where the prescaler is all ones ("dwell end"), the synchronised columns are sampled for the current row.
  - In that same cycle Rows rotates left: 1110 -> 1101 -> 1011 -> 0111 -> 1110.
- Key map (row index = position of the low Rows bit, col index = Cols bit):
  - r0: 1,2,3,A
  - r1: 4,5,6,B
  - r2: 7,8,9,C
  - r3: *,0,#,D
  - Codes: digits = their value; A..D = 10..13; * = 14; # = 15.
- Scan result is formed at the dwell end of row 3 from that scan's four samples:
  - NONE: no low column in any row.
  - SINGLE(code): exactly one low bit across all four samples.
  - MULTI: more than one low bit. MULTI is treated as NONE in IDLE and in DEBOUNCE_PRESS.
- State machine (evaluated only on scan results; count saturates at DEBOUNCE_SCANS):
  - IDLE:
    - SINGLE(k) -> DEBOUNCE_PRESS, cand=k, count=1.
  - DEBOUNCE_PRESS:
    - SINGLE(cand): count+1. When count reaches DEBOUNCE_SCANS -> HELD; in that cycle KeyCode=cand, KeyValid=1 for one cycle, KeyDown=1.
    - SINGLE(other): cand=other, count=1.
    - NONE/MULTI -> IDLE.
  - HELD:
    - NONE -> DEBOUNCE_RELEASE, count=1.
    - Any key or MULTI: stay. No rollover and no second pulse.
  - DEBOUNCE_RELEASE:
    - NONE: count+1. When count reaches DEBOUNCE_SCANS -> IDLE, KeyDown=0.
    - Any key -> HELD.
- Latency:
  - Acceptance occurs at the DEBOUNCE_SCANS-th consecutive matching scan end.
  - From first stable contact: at most (DEBOUNCE_SCANS+1) * 4 * 2^SCAN_DIV_BITS cycles.
- KeyValid is never asserted for two consecutive cycles. Asserting Reset mid-debounce abandons the candidate; no pulse is produced.

Decomposition:
- keypad_pkg holds:
  - state enum {IDLE, DEBOUNCE_PRESS, HELD, DEBOUNCE_RELEASE};
  - scan-result kind enum {NONE, SINGLE, MULTI};
  - KEY_STAR=14 and KEY_HASH=15;
  - the 16-entry row/col-to-code map constant.
- One sub-module: keypad_col_sync, a 4-bit two-flop synchroniser with async active-low reset to 4'hF.

Test Plan (SCAN_DIV_BITS=4, DEBOUNCE_SCANS=3: dwell 16 cycles, scan 64 cycles; the bench models the matrix by pulling Cols[c] low while Rows[r]==0):
- Reset: pulse Reset low mid-cycle -> outputs go immediately to Rows=1110, KeyValid=0, KeyDown=0, KeyCode=0. After release, Rows=1101 after 16 cycles and 1110 again after 64 cycles.
- Clean press and hold of '5' (r1,c1) for 6 scans -> exactly one KeyValid pulse within 256 cycles, with KeyCode=5, KeyBCD=6'd5, KeyDown=1 until release plus 3 empty scans.
- Bounce: '#' (r3,c2) present for 1 scan, absent 1 scan, present 1 scan, then released -> KeyValid never asserts and KeyDown stays 0.
- Two keys '1' and '2' pressed together from IDLE for 5 scans -> no KeyValid. Then release '2' and keep '1' -> one pulse with KeyCode=1.
- Rollover: hold 'A' until accepted (KeyCode=10), then add '0' and later drop 'A' while keeping '0' -> no new pulse and KeyDown stays 1. After all keys are released for 3 scans, KeyDown=0.
- Reset mid-debounce: '9' held for 2 scans, assert Reset, release Reset, then no keys -> KeyValid never asserts and KeyCode=0.

Source files
------------

// File: rtl/keypad_pkg.sv
// Shared types and key map for the 4x4 matrix keypad scanner.
package keypad_pkg;

    typedef enum logic [1:0] {IDLE, DEBOUNCE_PRESS, HELD, DEBOUNCE_RELEASE} state_t;
    typedef enum logic [1:0] {NONE, SINGLE, MULTI} scan_kind_t;

    localparam logic [3:0] KEY_STAR = 4'd14;
    localparam logic [3:0] KEY_HASH = 4'd15;

    // Indexed by {row, col}; row 0 is the top row of the keypad.
    localparam logic [3:0] KEY_MAP [0:15] = '{
        4'd1,     4'd2, 4'd3,     4'd10,
        4'd4,     4'd5, 4'd6,     4'd11,
        4'd7,     4'd8, 4'd9,     4'd12,
        KEY_STAR, 4'd0, KEY_HASH, 4'd13
    };

    function automatic logic [3:0] key_lookup(input logic [1:0] row, input logic [1:0] col);
        return KEY_MAP[{row, col}];
    endfunction

endpackage

// File: rtl/keypad_col_sync.sv
// Two-flop synchroniser for the asynchronous, active-low column returns.
module keypad_col_sync (
    input  logic       Clk,
    input  logic       Reset,
    input  logic [3:0] Cols,
    output logic [3:0] ColsSync
);

    logic [3:0] meta;

    // Idle columns read high, so reset to the "no key" value.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            meta     <= 4'hF;
            ColsSync <= 4'hF;
        end else begin
            meta     <= Cols;
            ColsSync <= meta;
        end
    end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: row strobing, whole-scan classification and
// scan-level debouncing with a one-cycle KeyValid pulse per accepted press.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV_BITS  = 17,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic [3:0] Cols,
    output logic [3:0] Rows,
    output logic       KeyValid,
    output logic [3:0] KeyCode,
    output logic [5:0] KeyBCD,
    output logic       KeyDown
);

    localparam logic [3:0] DEB_N = 4'(DEBOUNCE_SCANS);

    logic [3:0]               cols_sync;
    logic [SCAN_DIV_BITS-1:0] prescaler;
    logic                     dwell_end;
    logic                     scan_done;
    logic [1:0]               row_idx;
    logic [3:0]               hits;
    logic [2:0]               hit_cnt;
    logic [1:0]               hit_col;
    logic [2:0]               sum_cnt;
    logic [1:0]               acc_cnt, new_cnt;
    logic [3:0]               acc_code, new_code;
    scan_kind_t               scan_kind;

    state_t     state, state_nxt;
    logic [3:0] cand, cand_nxt;
    logic [3:0] count, count_nxt, count_inc;
    logic [3:0] code_nxt;
    logic       valid_nxt, down_nxt;

    keypad_col_sync u_col_sync (
        .Clk      (Clk),
        .Reset    (Reset),
        .Cols     (Cols),
        .ColsSync (cols_sync)
    );

    assign dwell_end = &prescaler;
    assign scan_done = dwell_end && (row_idx == 2'd3);
    assign KeyBCD    = {2'b00, KeyCode};

    always_comb begin
        row_idx = 2'd0;
        case (Rows)
            4'b1101: row_idx = 2'd1;
            4'b1011: row_idx = 2'd2;
            4'b0111: row_idx = 2'd3;
            default: row_idx = 2'd0;
        endcase
    end

    // Fold this row's sample into the running scan tally; the count saturates
    // at 2 because only "none / one / more than one" matters.
    always_comb begin
        hits    = ~cols_sync;
        hit_cnt = 3'($countones(hits));
        hit_col = 2'd0;
        for (int c = 3; c >= 0; c--) begin
            if (hits[c]) hit_col = 2'(c);
        end
        sum_cnt  = 3'(acc_cnt) + hit_cnt;
        new_cnt  = (sum_cnt > 3'd2) ? 2'd2 : sum_cnt[1:0];
        new_code = (acc_cnt == 2'd0) ? key_lookup(row_idx, hit_col) : acc_code;
        case (new_cnt)
            2'd0:    scan_kind = NONE;
            2'd1:    scan_kind = SINGLE;
            default: scan_kind = MULTI;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            prescaler <= '0;
            Rows      <= 4'b1110;
            acc_cnt   <= 2'd0;
            acc_code  <= 4'd0;
        end else begin
            prescaler <= prescaler + SCAN_DIV_BITS'(1);
            if (dwell_end) begin
                Rows     <= {Rows[2:0], Rows[3]};
                acc_cnt  <= scan_done ? 2'd0 : new_cnt;
                acc_code <= new_code;
            end
        end
    end

    assign count_inc = (count == DEB_N) ? count : count + 4'd1;

    always_comb begin
        state_nxt = state;
        cand_nxt  = cand;
        count_nxt = count;
        code_nxt  = KeyCode;
        valid_nxt = 1'b0;
        down_nxt  = KeyDown;
        if (scan_done) begin
            case (state)
                IDLE: begin
                    if (scan_kind == SINGLE) begin
                        state_nxt = DEBOUNCE_PRESS;
                        cand_nxt  = new_code;
                        count_nxt = 4'd1;
                    end
                end
                DEBOUNCE_PRESS: begin
                    if (scan_kind != SINGLE) begin
                        state_nxt = IDLE;
                    end else if (new_code == cand) begin
                        count_nxt = count_inc;
                        if (count_inc == DEB_N) begin
                            state_nxt = HELD;
                            code_nxt  = cand;
                            valid_nxt = 1'b1;
                            down_nxt  = 1'b1;
                        end
                    end else begin
                        cand_nxt  = new_code;
                        count_nxt = 4'd1;
                    end
                end
                HELD: begin
                    if (scan_kind == NONE) begin
                        state_nxt = DEBOUNCE_RELEASE;
                        count_nxt = 4'd1;
                    end
                end
                DEBOUNCE_RELEASE: begin
                    if (scan_kind != NONE) begin
                        state_nxt = HELD;
                    end else begin
                        count_nxt = count_inc;
                        if (count_inc == DEB_N) begin
                            state_nxt = IDLE;
                            down_nxt  = 1'b0;
                        end
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state    <= IDLE;
            cand     <= 4'd0;
            count    <= 4'd0;
            KeyCode  <= 4'd0;
            KeyValid <= 1'b0;
            KeyDown  <= 1'b0;
        end else begin
            state    <= state_nxt;
            cand     <= cand_nxt;
            count    <= count_nxt;
            KeyCode  <= code_nxt;
            KeyValid <= valid_nxt;
            KeyDown  <= down_nxt;
        end
    end

endmodule

// File: tb/tb_keypad_scanner.sv
// Self-checking bench: models the key matrix and predicts outputs per full scan.
module tb_keypad_scanner;

    localparam int SDB  = 4;
    localparam int DEB  = 3;
    localparam int SCAN = 4 * (1 << SDB);
    localparam int DWELL = 1 << SDB;

    logic       clk;
    logic       reset;
    logic [3:0] cols;
    logic [3:0] rows;
    logic       key_valid;
    logic [3:0] key_code;
    logic [5:0] key_bcd;
    logic       key_down;

    logic [15:0] key_mask;
    int          n_checks;
    int          n_fail;
    int          doubles;
    logic        prev_kv;

    // Reference model state (scan-level abstraction)
    int          m_state;
    int          m_cand;
    int          m_cnt;
    logic [3:0]  m_code;
    logic        m_down;
    string       key_chars = "123A456B789C*0#D";

    keypad_scanner #(
        .SCAN_DIV_BITS  (SDB),
        .DEBOUNCE_SCANS (DEB)
    ) dut (
        .Clk      (clk),
        .Reset    (reset),
        .Cols     (cols),
        .Rows     (rows),
        .KeyValid (key_valid),
        .KeyCode  (key_code),
        .KeyBCD   (key_bcd),
        .KeyDown  (key_down)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Matrix: a pressed key shorts its column to the currently strobed row.
    always_comb begin
        cols = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (!rows[r] && key_mask[r*4+c]) cols[c] = 1'b0;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int key_of(input int idx);
        byte ch;
        ch = key_chars[idx];
        if (ch >= "0" && ch <= "9") return ch - "0";
        if (ch >= "A" && ch <= "D") return ch - "A" + 10;
        if (ch == "*") return 14;
        return 15;
    endfunction

    task automatic model_reset();
        m_state = 0;
        m_cand  = 0;
        m_cnt   = 0;
        m_code  = 4'd0;
        m_down  = 1'b0;
    endtask

    // 0 idle, 1 confirming press, 2 held, 3 confirming release
    task automatic model_step(input logic [15:0] mask, output logic pulse);
        int n;
        int k;
        n = $countones(mask);
        k = -1;
        pulse = 1'b0;
        if (n == 1)
            for (int i = 0; i < 16; i++) if (mask[i]) k = key_of(i);
        case (m_state)
            0: if (k >= 0) begin m_state = 1; m_cand = k; m_cnt = 1; end
            1: begin
                if (k < 0) m_state = 0;
                else if (k == m_cand) begin
                    m_cnt++;
                    if (m_cnt >= DEB) begin
                        m_state = 2; m_code = 4'(k); m_down = 1'b1; pulse = 1'b1;
                    end
                end else begin
                    m_cand = k; m_cnt = 1;
                end
            end
            2: if (n == 0) begin m_state = 3; m_cnt = 1; end
            default: begin
                if (n != 0) m_state = 2;
                else begin
                    m_cnt++;
                    if (m_cnt >= DEB) begin m_state = 0; m_down = 1'b0; end
                end
            end
        endcase
    endtask

    // Holds one key mask for exactly one full scan, starting just after row 0 is strobed.
    task automatic run_scan(input logic [15:0] mask);
        int   pulses;
        logic exp_pulse;
        key_mask = mask;
        pulses = 0;
        for (int i = 1; i <= SCAN; i++) begin
            @(negedge clk);
            if (key_valid) begin
                pulses++;
                if (prev_kv) doubles++;
            end
            prev_kv = key_valid;
            if (i == DWELL) chk("rows_r1", rows, 4'b1101);
            if (i == SCAN)  chk("rows_r0", rows, 4'b1110);
        end
        model_step(mask, exp_pulse);
        chk("kv_pulses", pulses, exp_pulse);
        chk("key_down", key_down, m_down);
        chk("key_code", key_code, m_code);
        chk("key_bcd", key_bcd, {2'b00, m_code});
    endtask

    task automatic do_reset();
        key_mask = 16'h0;
        #3;
        reset = 1'b0;
        #1;
        chk("rst_rows", rows, 4'b1110);
        chk("rst_kv", key_valid, 1'b0);
        chk("rst_kd", key_down, 1'b0);
        chk("rst_kc", key_code, 4'd0);
        chk("rst_bcd", key_bcd, 6'd0);
        model_reset();
        prev_kv = 1'b0;
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic run_hold(input logic [15:0] mask, input int scans);
        for (int s = 0; s < scans; s++) run_scan(mask);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        doubles  = 0;
        prev_kv  = 1'b0;
        key_mask = 16'h0;
        reset    = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        do_reset();

        // Clean press of '5' then release
        run_hold(16'h0001 << 5, 6);
        run_hold(16'h0, 4);

        // Bouncing '#'
        run_scan(16'h0001 << 14);
        run_scan(16'h0);
        run_scan(16'h0001 << 14);
        run_hold(16'h0, 4);

        // '1' and '2' together, then '1' alone
        run_hold(16'h0003, 5);
        run_hold(16'h0001, 4);
        run_hold(16'h0, 4);

        // Rollover: 'A', then 'A'+'0', then '0' alone
        run_hold(16'h0001 << 3, 4);
        run_hold((16'h0001 << 3) | (16'h0001 << 13), 2);
        run_hold(16'h0001 << 13, 2);
        run_hold(16'h0, 4);

        // Reset mid-debounce of '9'
        run_hold(16'h0001 << 10, 2);
        do_reset();
        run_hold(16'h0, 3);

        // Randomised key sequences with occasional resets
        for (int t = 0; t < 30; t++) begin
            logic [15:0] m;
            int kind;
            kind = int'($urandom_range(0, 3));
            m = 16'h0;
            if (kind == 1 || kind == 2) m = 16'h0001 << $urandom_range(0, 15);
            if (kind == 3) m = (16'h0001 << $urandom_range(0, 15)) | (16'h0001 << $urandom_range(0, 15));
            run_hold(m, int'($urandom_range(1, 5)));
            if ($urandom_range(0, 15) == 0) do_reset();
        end
        run_hold(16'h0, 4);

        chk("kv_consecutive", doubles, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
